// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush and memory-wait FSM.
// Optional stalled-cycle performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_TIMEOUT   = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [ADDRESS_WIDTH-1:0] RdE,
    input  logic [ADDRESS_WIDTH-1:0] RdM,
    input  logic [ADDRESS_WIDTH-1:0] RdW,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic [1:0]               ResultSrcE,
    input  logic                     PCSrcE,
    input  logic                     MemReqM,
    input  logic                     MemReadyM,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     StallM,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushW,
    output logic [1:0]               ForwardAE,
    output logic [1:0]               ForwardBE,
    output logic                     MemErr,
    output logic [DATA_WIDTH-1:0]    StallCycles
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              mem_err;
    logic              lw_stall;
    logic              mem_stall;

    function automatic logic [1:0] fwd_sel(input logic [ADDRESS_WIDTH-1:0] rs);
        if (RegWriteM && RdM != '0 && RdM == rs)      return 2'b10;
        else if (RegWriteW && RdW != '0 && RdW == rs) return 2'b01;
        else                                          return 2'b00;
    endfunction

    assign ForwardAE = fwd_sel(Rs1E);
    assign ForwardBE = fwd_sel(Rs2E);

    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Reset masks the ERR state so outputs behave as if already back in RUN.
    assign mem_stall = (MemReqM && !MemReadyM) || (!RST && state == ERR);

    // Holding E/M keeps the load-use and branch inputs alive, so they reappear after the stall.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall | PCSrcE;
            FlushD = PCSrcE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (MemReqM && !MemReadyM) begin
                        state <= WAIT;
                        wcnt  <= WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (MemReadyM) begin
                        state <= RUN;
                    end else if (wcnt == WCNT_W'(MEM_TIMEOUT)) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                ERR:     mem_err <= 1'b1;
                default: state   <= RUN;
            endcase
        end
    end

    assign MemErr = mem_err;

`ifdef HAZARD_PERF_EN
    logic [DATA_WIDTH-1:0] stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST)         stall_cnt <= '0;
        else if (StallF) stall_cnt <= stall_cnt + 1'b1;
    end

    assign StallCycles = stall_cnt;
`else
    assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: forwarding, load-use, branch, memory wait, timeout, reset, perf counter.
module tb_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MemErr;
    logic [31:0] StallCycles;
    logic [6:0]  ctrl;

    int total  = 0;
    int passed = 0;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_LWBR = 7'b1100110;
    localparam logic [6:0] C_MEM  = 7'b1111001;

    hazard_ctrl #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .MEM_TIMEOUT(16)) dut (
        .CLK(CLK), .RST(RST),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemErr(MemErr), .StallCycles(StallCycles)
    );

    assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
        PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0; #1;
        chk("reset_ctrl", 32'(ctrl), 32'(C_NONE));
        chk("reset_memerr", 32'(MemErr), 0);
        chk("reset_cycles", StallCycles, 0);
        chk("reset_fwd", {28'd0, ForwardAE, ForwardBE}, 0);

        // Forwarding priority and x0 exclusion
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 5; #1;
        chk("fwdA_mem", 32'(ForwardAE), 32'(2'b10));
        chk("fwdB_mem", 32'(ForwardBE), 32'(2'b10));
        RdM = 0; #1;
        chk("fwdA_wb", 32'(ForwardAE), 32'(2'b01));
        chk("fwdB_wb", 32'(ForwardBE), 32'(2'b01));
        RegWriteW = 0; #1;
        chk("fwdA_nowe", 32'(ForwardAE), 0);
        RegWriteW = 1; RdW = 0; Rs1E = 0; #1;
        chk("fwdA_x0", 32'(ForwardAE), 0);
        RdM = 7; RdW = 5; Rs1E = 5; Rs2E = 7; #1;
        chk("fwdA_split", 32'(ForwardAE), 32'(2'b01));
        chk("fwdB_split", 32'(ForwardBE), 32'(2'b10));
        clear_inputs(); #1;

        // Load-use
        ResultSrcE = 2'b01; RdE = 3; Rs2D = 3; #1;
        chk("lw_stall", 32'(ctrl), 32'(C_LW));
        tick();
        ResultSrcE = 2'b00; #1;
        chk("lw_done", 32'(ctrl), 32'(C_NONE));
        ResultSrcE = 2'b01; RdE = 0; Rs2D = 0; #1;
        chk("lw_x0", 32'(ctrl), 32'(C_NONE));
        ResultSrcE = 2'b10; RdE = 3; Rs1D = 3; #1;
        chk("lw_notload", 32'(ctrl), 32'(C_NONE));
        clear_inputs(); #1;

        // Branch alone and combined with load-use
        PCSrcE = 1; #1;
        chk("branch", 32'(ctrl), 32'(C_BR));
        ResultSrcE = 2'b01; RdE = 4; Rs1D = 4; #1;
        chk("lw_branch", 32'(ctrl), 32'(C_LWBR));
        tick();
        clear_inputs(); #1;

        // Memory wait of 3 cycles with a branch deferred under it
        MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("memwait_%0d", i), 32'(ctrl), 32'(C_MEM));
            tick();
        end
        MemReadyM = 1; #1;
        chk("memwait_release", 32'(ctrl), 32'(C_BR));
        tick();
        clear_inputs(); #1;
        chk("memwait_after", 32'(ctrl), 32'(C_NONE));
        chk("memwait_err", 32'(MemErr), 0);

        // Ready in the same cycle as the request
        MemReqM = 1; MemReadyM = 1; #1;
        chk("ready_same", 32'(ctrl), 32'(C_NONE));
        tick();
        MemReqM = 0; #1;
        chk("ready_same_after", 32'(ctrl), 32'(C_NONE));

        // Timeout: 17 not-ready cycles reach ERR
        MemReqM = 1; MemReadyM = 0;
        for (int i = 1; i <= 17; i++) begin
            #1;
            if (i == 1 || i == 17) chk($sformatf("timeout_stall_%0d", i), 32'(ctrl), 32'(C_MEM));
            tick();
            if (i == 16) chk("timeout_err_early", 32'(MemErr), 0);
        end
        chk("timeout_err", 32'(MemErr), 1);
        MemReqM = 0; MemReadyM = 1; #1;
        chk("err_hold", 32'(ctrl), 32'(C_MEM));
        tick();
        chk("err_sticky", 32'(MemErr), 1);
        chk("err_hold2", 32'(ctrl), 32'(C_MEM));
        RST = 1; MemReqM = 0; #1;
        chk("err_in_reset", 32'(ctrl), 32'(C_NONE));
        tick();
        RST = 0; clear_inputs(); #1;
        chk("err_cleared", 32'(MemErr), 0);
        chk("err_cleared_ctrl", 32'(ctrl), 32'(C_NONE));

        // Reset in the middle of a wait
        MemReqM = 1; MemReadyM = 0;
        tick(); tick(); tick();
        RST = 1; MemReqM = 0; tick();
        RST = 0; #1;
        chk("midwait_reset", 32'(ctrl), 32'(C_NONE));
        chk("midwait_err", 32'(MemErr), 0);

        // Performance counter: 5 stalled cycles after reset
        RST = 1; tick();
        RST = 0;
        ResultSrcE = 2'b01; RdE = 2; Rs1D = 2;
        for (int i = 0; i < 5; i++) tick();
        clear_inputs(); #1;
`ifdef HAZARD_PERF_EN
        chk("perf_count", StallCycles, 5);
`else
        chk("perf_count", StallCycles, 0);
`endif
        tick();
`ifdef HAZARD_PERF_EN
        chk("perf_hold", StallCycles, 5);
`else
        chk("perf_hold", StallCycles, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
